// File: rtl/ripple_count_ctrl_if.sv
// Request/grant and external-counter signals for ripple_count_ctrl.
interface ripple_count_ctrl_if #(
  parameter int WIDTH = 4
);
  logic             req0;
  logic             req1;
  logic [WIDTH-1:0] tgt0;
  logic [WIDTH-1:0] tgt1;
  logic [WIDTH-1:0] cnt_q;
  logic             cnt_clr;
  logic             cnt_tick;
  logic [1:0]       gnt;
  logic             busy;
  logic             done;
  logic             err;

  modport master (
    output req0, req1, tgt0, tgt1, cnt_q,
    input  cnt_clr, cnt_tick, gnt, busy, done, err
  );

  modport slave (
    input  req0, req1, tgt0, tgt1, cnt_q,
    output cnt_clr, cnt_tick, gnt, busy, done, err
  );
endinterface

// File: rtl/ripple_count_ctrl.sv
// Two-requester controller that clears and ticks an external ripple counter, then checks it.
// Optional RC_CTRL_CHECK_EN enables the cnt_q vs. target comparison driving err.
module ripple_count_ctrl #(
  parameter int WIDTH      = 4,
  parameter int SETTLE_CYC = 2
) (
  input logic                clk,
  input logic                reset,
  ripple_count_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_CLR_WAIT,
    S_TICK,
    S_TICK_WAIT,
    S_CHECK,
    S_DONE
  } state_e;

  localparam logic [3:0] WAIT_LAST = 4'(SETTLE_CYC - 1);

  state_e           state_q, state_d;
  logic [3:0]       wait_q, wait_d;
  logic [WIDTH-1:0] tgt_q, tgt_d;
  logic [WIDTH-1:0] issued_q, issued_d;
  logic             ptr_q, ptr_d;
  logic [1:0]       gnt_q, gnt_d;
  logic             clr_q, clr_d;
  logic             tick_q, tick_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic             grant1;

  // Both requesting: serve the one the pointer did not serve last.
  assign grant1 = bus.req1 & (~bus.req0 | ~ptr_q);

  always_comb begin
    state_d  = state_q;
    wait_d   = wait_q;
    tgt_d    = tgt_q;
    issued_d = issued_q;
    ptr_d    = ptr_q;
    gnt_d    = gnt_q;
    err_d    = err_q;
    clr_d    = 1'b0;
    tick_d   = 1'b0;
    done_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.req0 | bus.req1) begin
          gnt_d    = grant1 ? 2'b10 : 2'b01;
          ptr_d    = grant1;
          tgt_d    = grant1 ? bus.tgt1 : bus.tgt0;
          issued_d = '0;
          err_d    = 1'b0;
          clr_d    = 1'b1;
          state_d  = S_CLEAR;
        end
      end
      S_CLEAR: begin
        wait_d  = '0;
        state_d = S_CLR_WAIT;
      end
      S_CLR_WAIT, S_TICK_WAIT: begin
        if (wait_q == WAIT_LAST) begin
          if (issued_q == tgt_q) begin
            state_d = S_CHECK;
          end else begin
            tick_d  = 1'b1;
            state_d = S_TICK;
          end
        end else begin
          wait_d = wait_q + 4'd1;
        end
      end
      S_TICK: begin
        // TICK is only entered with issued < target, so this cannot wrap.
        issued_d = issued_q + WIDTH'(1);
        wait_d   = '0;
        state_d  = S_TICK_WAIT;
      end
      S_CHECK: begin
`ifdef RC_CTRL_CHECK_EN
        err_d = (bus.cnt_q != tgt_q);
`endif
        done_d  = 1'b1;
        state_d = S_DONE;
      end
      S_DONE: begin
        gnt_d   = 2'b00;
        state_d = S_IDLE;
      end
      default: begin
        gnt_d   = 2'b00;
        state_d = S_IDLE;
      end
    endcase
    busy_d = (state_d != S_IDLE);
  end

  // Pulse outputs are decoded from the next state so they line up with the state itself.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      wait_q   <= '0;
      tgt_q    <= '0;
      issued_q <= '0;
      ptr_q    <= 1'b1;
      gnt_q    <= 2'b00;
      clr_q    <= 1'b0;
      tick_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      wait_q   <= wait_d;
      tgt_q    <= tgt_d;
      issued_q <= issued_d;
      ptr_q    <= ptr_d;
      gnt_q    <= gnt_d;
      clr_q    <= clr_d;
      tick_q   <= tick_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  assign bus.cnt_clr  = clr_q;
  assign bus.cnt_tick = tick_q;
  assign bus.gnt      = gnt_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.err      = err_q;

endmodule

// File: tb/tb_ripple_count_ctrl.sv
// Randomized bench for ripple_count_ctrl with a behavioural ripple-counter model.
module tb_ripple_count_ctrl;
  localparam int WIDTH = 4;
  localparam int S     = 2;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  ripple_count_ctrl_if #(.WIDTH(WIDTH)) bus();
  ripple_count_ctrl #(.WIDTH(WIDTH), .SETTLE_CYC(S)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;
  int drop_at = -1;
  int tick_n;
  logic [WIDTH-1:0] cnt_m;
  bit ptr_m;

  // External counter: clear on cnt_clr, count on cnt_tick, optionally lose one tick.
  assign bus.cnt_q = cnt_m;
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_m  <= '0;
      tick_n <= 0;
    end else if (bus.cnt_clr) begin
      cnt_m  <= '0;
      tick_n <= 0;
    end else if (bus.cnt_tick) begin
      tick_n <= tick_n + 1;
      if (tick_n != drop_at) cnt_m <= cnt_m + 1'b1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic run_job(input bit drop_req);
    int grant, n, cyc, ticks, lim, exp_cnt, exp_err;
    bit got, prev, cur;
    logic [1:0] eg;
    if (bus.req0 && bus.req1) grant = ptr_m ? 0 : 1;
    else                      grant = bus.req1 ? 1 : 0;
    n     = grant ? int'(bus.tgt1) : int'(bus.tgt0);
    ptr_m = grant[0];
    eg    = grant ? 2'b10 : 2'b01;
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      @(negedge clk);
      got = (bus.gnt != 2'b00);
    end
    chk("grant_seen", got, 1);
    if (!got) return;
    chk("gnt", bus.gnt, eg);
    chk("clr_first", bus.cnt_clr, 1);
    chk("busy_first", bus.busy, 1);
    if (drop_req) begin
      bus.req0 = 1'b0;
      bus.req1 = 1'b0;
    end
    cyc   = 1;
    ticks = 0;
    prev  = bus.cnt_clr | bus.cnt_tick;
    lim   = 3 + S + n * (1 + S) + 8;
    while (!bus.done && cyc < lim) begin
      @(negedge clk);
      cyc++;
      cur = bus.cnt_clr | bus.cnt_tick;
      chk("pulse_sep", (bus.cnt_clr && bus.cnt_tick) || (prev && cur), 0);
      prev = cur;
      if (bus.cnt_tick) begin
        chk("tick_cyc", cyc, 2 + S + ticks * (1 + S));
        ticks++;
      end
      if (bus.cnt_clr) chk("clr_once", cyc, 1);
      chk("gnt_hold", bus.gnt, eg);
      chk("busy", bus.busy, 1);
    end
    exp_cnt = n - ((drop_at >= 0 && drop_at < n) ? 1 : 0);
`ifdef RC_CTRL_CHECK_EN
    exp_err = (exp_cnt != n) ? 1 : 0;
`else
    exp_err = 0;
`endif
    chk("done_cyc", cyc, 3 + S + n * (1 + S));
    chk("ticks", ticks, n);
    chk("cnt_q", bus.cnt_q, exp_cnt);
    chk("err", bus.err, exp_err);
    @(negedge clk);
    chk("idle_gnt", bus.gnt, 0);
    chk("idle_busy", bus.busy, 0);
    chk("done_pulse", bus.done, 0);
    chk("err_sticky", bus.err, exp_err);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_gnt"}, bus.gnt, 0);
    chk({tag, "_busy"}, bus.busy, 0);
    chk({tag, "_done"}, bus.done, 0);
    chk({tag, "_err"}, bus.err, 0);
    chk({tag, "_clr"}, bus.cnt_clr, 0);
    chk({tag, "_tick"}, bus.cnt_tick, 0);
  endtask

  initial begin
    bit got;
    reset    = 1'b1;
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    bus.tgt0 = '0;
    bus.tgt1 = '0;
    ptr_m    = 1'b1;
    repeat (3) @(negedge clk);
    chk_all_zero("rst");
    reset = 1'b0;
    @(negedge clk);

    // Contended requests alternate, requester 0 first.
    bus.req0 = 1'b1; bus.req1 = 1'b1;
    bus.tgt0 = 4'd1; bus.tgt1 = 4'd2;
    repeat (4) run_job(1'b0);
    bus.req0 = 1'b0; bus.req1 = 1'b0;

    bus.req0 = 1'b1; bus.tgt0 = 4'd3;
    run_job(1'b1);

    bus.req1 = 1'b1; bus.tgt1 = 4'd0;
    run_job(1'b1);

    drop_at  = 2;
    bus.req0 = 1'b1; bus.tgt0 = 4'd5;
    run_job(1'b1);
    drop_at  = -1;

    bus.req0 = 1'b1; bus.tgt0 = 4'd15;
    run_job(1'b1);

    // Reset in the first TICK_WAIT of a long job.
    bus.req0 = 1'b1; bus.tgt0 = 4'd15;
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      @(negedge clk);
      got = (bus.gnt != 2'b00);
    end
    chk("rst_job_grant", got, 1);
    repeat (4) @(negedge clk);
    reset = 1'b1;
    #1;
    chk_all_zero("midrst");
    @(negedge clk);
    reset    = 1'b0;
    ptr_m    = 1'b1;
    bus.tgt0 = 4'd2;
    run_job(1'b1);

    for (int j = 0; j < 12; j++) begin
      bus.req0 = 1'($urandom);
      bus.req1 = 1'($urandom);
      if (!bus.req0 && !bus.req1) bus.req0 = 1'b1;
      bus.tgt0 = WIDTH'($urandom_range(0, 15));
      bus.tgt1 = WIDTH'($urandom_range(0, 15));
      drop_at  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 14)) : -1;
      run_job(1'($urandom));
    end
    drop_at = -1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
